// File: rtl/tempsens_reader_pkg.sv
// Shared types and constants for the tempsens pin-interface readout controller.
package tempsens_reader_pkg;

  localparam int unsigned RES_W   = 20;
  localparam int unsigned DAC_W   = 6;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned RETRY_W = 4;

  localparam logic [BYTE_W-1:0] SIGNATURE = 8'h69;

  localparam logic [SEL_W-1:0] SEL_LO  = 2'b00;
  localparam logic [SEL_W-1:0] SEL_MID = 2'b01;
  localparam logic [SEL_W-1:0] SEL_HI  = 2'b10;
  localparam logic [SEL_W-1:0] SEL_SIG = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SIG,
    ST_LO,
    ST_MID,
    ST_HI,
    ST_CHK,
    ST_DONE
  } state_e;

  // Output-select driven onto the tile while sitting in a given state.
  function automatic logic [SEL_W-1:0] sel_for_state(state_e s);
    case (s)
      ST_LO, ST_CHK: return SEL_LO;
      ST_MID:        return SEL_MID;
      ST_HI:         return SEL_HI;
      default:       return SEL_SIG;
    endcase
  endfunction

endpackage

// File: rtl/tempsens_reader_phase_cnt.sv
// Loadable down-counter timing one read phase.
// Ports: load_i/load_val_i restart the count; tc_o is high while the count is zero.
module tempsens_reader_phase_cnt
  import tempsens_reader_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tc_q;

  // Count down to zero and hold there until reloaded.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Terminal count is registered from the next count so it lines up with cnt_q == 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tc_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= (cnt_d == '0);
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/tempsens_reader.sv
// Readout controller for the tempsens tile pins: drives {sel, dac_code} onto the
// tile inputs, reassembles the 20-bit result from the byte-wide outputs, checks the
// signature and tearing, and hands the word out over valid/ready.
// Ports: i_start/i_dac_code request a read; o_ui_in/i_uo_out are the tile pins;
// o_res/o_valid/i_ready is the result handshake; o_busy/o_err report status.
module tempsens_reader
  import tempsens_reader_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [DAC_W-1:0]  i_dac_code,
  output logic [BYTE_W-1:0] o_ui_in,
  input  logic [BYTE_W-1:0] i_uo_out,
  output logic [RES_W-1:0]  o_res,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_err
);

  localparam logic [CNT_W-1:0]   SETTLE_LD = CNT_W'(SETTLE_CYCLES);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

  state_e              state_q, state_d;
  logic [DAC_W-1:0]    dac_q, dac_d;
  logic [RES_W-1:0]    res_q, res_d;
  logic [RES_W-1:0]    ores_q, ores_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic                err_q, err_d;
  logic [BYTE_W-1:0]   ui_q;
  logic                valid_q, busy_q;
  logic                cnt_load;
  logic                phase_tc;

  tempsens_reader_phase_cnt u_phase_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (SETTLE_LD),
    .tc_o       (phase_tc)
  );

  // Next-state and datapath updates; every read phase acts only on its last cycle.
  always_comb begin
    state_d  = state_q;
    dac_d    = dac_q;
    res_d    = res_q;
    ores_d   = ores_q;
    retry_d  = retry_q;
    err_d    = err_q;
    cnt_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          dac_d    = i_dac_code;
          err_d    = 1'b0;
          retry_d  = '0;
          cnt_load = 1'b1;
          state_d  = ST_SIG;
        end
      end
      ST_SIG: begin
        if (phase_tc) begin
          cnt_load = 1'b1;
          if (i_uo_out != SIGNATURE) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_LO;
          end
        end
      end
      ST_LO: begin
        if (phase_tc) begin
          cnt_load    = 1'b1;
          res_d[7:0]  = i_uo_out;
          state_d     = ST_MID;
        end
      end
      ST_MID: begin
        if (phase_tc) begin
          cnt_load    = 1'b1;
          res_d[15:8] = i_uo_out;
          state_d     = ST_HI;
        end
      end
      ST_HI: begin
        if (phase_tc) begin
          cnt_load = 1'b1;
          if (i_uo_out[7:4] != 4'h0) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            res_d[19:16] = i_uo_out[3:0];
            state_d      = ST_CHK;
          end
        end
      end
      ST_CHK: begin
        // A changed LO byte means the sensor updated mid-read; re-read the word.
        if (phase_tc) begin
          cnt_load = 1'b1;
          if (i_uo_out == res_q[7:0]) begin
            ores_d  = res_q;
            state_d = ST_DONE;
          end else if (retry_q < RETRY_LIM) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = ST_LO;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_DONE: begin
        if (valid_q && i_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs, all derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dac_q   <= '0;
      res_q   <= '0;
      ores_q  <= '0;
      retry_q <= '0;
      err_q   <= 1'b0;
      ui_q    <= {SEL_SIG, DAC_W'(0)};
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dac_q   <= dac_d;
      res_q   <= res_d;
      ores_q  <= ores_d;
      retry_q <= retry_d;
      err_q   <= err_d;
      ui_q    <= {sel_for_state(state_d), dac_d};
      valid_q <= (state_d == ST_DONE);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign o_ui_in = ui_q;
  assign o_res   = ores_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;
  assign o_err   = err_q;

endmodule

// File: doc/tempsens_reader.md
# tempsens_reader

Readout controller for the other end of the tempsens TinyTapeout pin interface. It drives the 8-bit dedicated-input bus (2-bit output select plus 6-bit DAC code) and reassembles the 20-bit sensor result from the byte-wide dedicated-output bus. It sits in the bring-up FPGA or a test harness, directly wired to the tile pins. It verifies the 0x69 signature and tear-free readout, then presents the word over a valid/ready handshake.

## Interface
- SETTLE_CYCLES, 4: cycles the select is held before the pin bus is sampled (covers pad and mux latency); legal range 1..255.
- MAX_RETRY, 3: tear-detect re-reads allowed before the error flag is set; legal range 0..15.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- i_start  input  1  request one readout; accepted only in IDLE.
- i_dac_code  input  6  DAC code; latched on accept.
- o_ui_in  output  8  to the tile's dedicated inputs: {sel[1:0], dac_code[5:0]}.
- i_uo_out  input  8  from the tile's dedicated outputs.
- o_res  output  20  assembled result; stable while o_valid=1.
- o_valid  output  1  result available.
- i_ready  input  1  consumer accepts o_res.
- o_busy  output  1  high in every state except IDLE.
- o_err  output  1  sticky failure flag; cleared on the next accepted start.

## Operation
- Select encodings: 00 = bits [7:0], 01 = bits [15:8], 10 = {4'b0, bits [19:16]}, 11 = signature 0x69.
- States: IDLE, SIG, LO, MID, HI, CHK, DONE.
- IDLE: o_ui_in = {2'b11, dac_q}.
  - i_start=1 latches dac_code, clears o_err and the retry count, then moves to SIG.
- Each read phase (SIG, LO, MID, HI, CHK) drives its select for SETTLE_CYCLES+1 cycles and samples i_uo_out at the edge that ends the phase. The phase counter is 8 bits.
- SIG: sample != 0x69 -> o_err=1, go to IDLE (no valid).
- LO, MID: capture byte into res[7:0] and res[15:8].
- HI: sample[7:4] != 0 -> o_err=1, go to IDLE. Otherwise res[19:16] = sample[3:0].
- CHK: re-reads sel=00 and compares against res[7:0]. This catches a sensor update mid-read.
  - Match -> DONE.
  - Mismatch with retry < MAX_RETRY -> retry+1, go to LO.
  - Otherwise -> o_err=1, go to IDLE.
- DONE: o_valid=1, o_res holds the captured word. When o_valid & i_ready at an edge, go to IDLE and drop o_valid.
- i_start outside IDLE is ignored, including in DONE. i_dac_code changes outside IDLE have no effect.
- Reset mid-operation: immediately returns to IDLE with reset values, and the partial word is discarded.

## Timing
- Reset values:
  - o_ui_in = 8'hC0
  - o_res = 0
  - o_valid = 0
  - o_busy = 0
  - o_err = 0
  - state IDLE, counters 0
- All outputs are registered; there is no combinational path from any input to any output.
- Start accepted at edge E0: SIG select appears after E0, and o_busy rises after E0.
- Clean read: o_valid rises after edge E0 + 5·(SETTLE_CYCLES+1), which is 25 cycles at default.
- Each retry adds 4·(SETTLE_CYCLES+1) cycles.
- If i_ready is already high when o_valid rises, the handshake completes at the next edge and IDLE follows.
- The earliest back-to-back start is accepted in the cycle after IDLE is re-entered.
- A failed signature is detected at E0+(SETTLE_CYCLES+1). At that edge o_err=1 and o_busy=0.

## Structure
- Package tempsens_reader_pkg holds:
  - the state enum
  - SEL_LO/SEL_MID/SEL_HI/SEL_SIG constants
  - SIGNATURE = 8'h69
  - RES_W = 20
- One sub-module is natural: tempsens_reader_phase_cnt, a loadable down-counter with a terminal-count pulse, reused by every read phase. Everything else stays in the top FSM.

## Test plan
- Pin model returns res=20'hA5C3E and sig 0x69; start with dac=6'h2A.
  - o_ui_in low bits = 0x2A throughout.
  - o_valid rises 25 cycles after start with o_res=0xA5C3E.
  - Holding i_ready=0 for 10 cycles keeps o_valid and o_res stable.
- Model returns 0x00 on sel=11 -> o_err=1 after 5 cycles, o_valid never asserts, o_busy=0.
- Model changes the LO byte from 0x3E to 0x3F between the LO and CHK samples once.
  - Exactly one retry, then o_res=0xA5C3F.
  - Latency 25+20 = 45 cycles.
- Model toggles the LO byte on every read -> o_err=1 after 3 retries, no valid.
- HI byte = 0x1A -> o_err=1 at the end of HI.
- rst_n pulsed low during MID -> all outputs at reset values asynchronously. A following start completes normally, and i_start pulses in DONE are ignored.
